clock_divider_ctrl: RTL and testbench



---
 rtl/clock_divider_pkg.sv | 19 +
 rtl/clock_divider_ctrl_cnt.sv | 53 +++++
 rtl/clock_divider_ctrl.sv | 112 +++++++++++
 tb/tb_clock_divider_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/clock_divider_pkg.sv
// Shared types and helpers for the clock divider controller: FSM state encoding,
// default divisor limits and the half-period decode point.
package clock_divider_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_e;

    localparam int unsigned MAX_DIV_DEF     = 255;
    localparam int unsigned DEFAULT_DIV_DEF = 9;

    // Count at which the half pulse fires; callers guarantee div >= 2.
    function automatic int unsigned half_point(input int unsigned div);
        return (div >> 1) - 1;
    endfunction

endpackage

// File: rtl/clock_divider_ctrl_cnt.sv
// Period counter with registered wrap/half decode. The flags are computed from
// the next count and next divisor so they line up with cnt_o in the same cycle.
module clock_divider_ctrl_cnt
    import clock_divider_pkg::*;
#(
    parameter int unsigned W           = 8,
    parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic [W-1:0] div_nxt_i,
    output logic [W-1:0] cnt_o,
    output logic         wrap_o,
    output logic         half_o
);

    localparam logic RST_HALF = (half_point(DEFAULT_DIV) == 0);

    logic [W-1:0] cnt_q, cnt_d;
    logic         wrap_q, wrap_d;
    logic         half_q, half_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = wrap_q ? '0 : cnt_q + W'(1);
        end
        // div_nxt_i is always a legal divisor (>= 2), so the subtraction cannot underflow.
        wrap_d = (cnt_d == div_nxt_i - W'(1));
        half_d = (cnt_d == W'(half_point(32'(div_nxt_i))));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
            half_q <= RST_HALF;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
            half_q <= half_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign wrap_o = wrap_q;
    assign half_o = half_q;

endmodule

// File: rtl/clock_divider_ctrl.sv
// Run-time sequencer for the odd/even clock dividers: accepts divisor and
// start/stop requests and applies them only on period boundaries.
module clock_divider_ctrl
    import clock_divider_pkg::*;
#(
    parameter int unsigned MAX_DIV     = MAX_DIV_DEF,
    parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF,
    parameter int unsigned W           = $clog2(MAX_DIV + 1)
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         cfg_valid_i,
    output logic         cfg_ready_o,
    input  logic [W-1:0] cfg_div_i,
    input  logic         cfg_en_i,
    output logic         run_o,
    output logic [W-1:0] div_o,
    output logic         odd_o,
    output logic [W-1:0] cnt_o,
    output logic         half_o,
    output logic         wrap_o,
    output logic         busy_o,
    output logic         err_o
);

    localparam logic [W-1:0] MAX_DIV_W = W'(MAX_DIV);
    localparam logic [W-1:0] MIN_DIV_W = W'(2);
    localparam logic [W-1:0] DEF_DIV_W = W'(DEFAULT_DIV);

    state_e       state_q;
    logic         run_q;
    logic [W-1:0] div_q, div_d;
    logic [W-1:0] pend_div_q;
    logic         pend_en_q;
    logic         err_q;

    logic         xfer, legal, start, apply;
    logic [W-1:0] cnt;
    logic         wrap_raw, half_raw;

    assign cfg_ready_o = (state_q != ST_PEND);
    assign xfer        = cfg_valid_i && cfg_ready_o;
    assign legal       = !cfg_en_i || (cfg_div_i >= MIN_DIV_W && cfg_div_i <= MAX_DIV_W);
    assign start       = (state_q == ST_IDLE) && xfer && cfg_en_i && legal;
    // A pending change lands on the wrap cycle; a request arriving with a wrap waits in PEND.
    assign apply       = (state_q == ST_PEND) && wrap_raw;
    assign div_d       = start ? cfg_div_i :
                         (apply && pend_en_q) ? pend_div_q : div_q;

    clock_divider_ctrl_cnt #(
        .W           (W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_cnt (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .en_i      (run_q),
        .clr_i     (start || apply),
        .div_nxt_i (div_d),
        .cnt_o     (cnt),
        .wrap_o    (wrap_raw),
        .half_o    (half_raw)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            run_q      <= 1'b0;
            div_q      <= DEF_DIV_W;
            pend_div_q <= DEF_DIV_W;
            pend_en_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            err_q <= xfer && !legal;
            div_q <= div_d;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_RUN;
                        run_q   <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (xfer && legal) begin
                        pend_div_q <= cfg_div_i;
                        pend_en_q  <= cfg_en_i;
                        state_q    <= ST_PEND;
                    end
                end
                ST_PEND: begin
                    if (wrap_raw) begin
                        state_q <= pend_en_q ? ST_RUN : ST_IDLE;
                        run_q   <= pend_en_q;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    run_q   <= 1'b0;
                end
            endcase
        end
    end

    assign run_o  = run_q;
    assign div_o  = div_q;
    assign odd_o  = div_q[0];
    assign cnt_o  = cnt;
    assign half_o = run_q && half_raw;
    assign wrap_o = run_q && wrap_raw;
    assign busy_o = (state_q == ST_PEND);
    assign err_o  = err_q;

endmodule

// File: tb/tb_clock_divider_ctrl.sv
// Scoreboard bench for clock_divider_ctrl: a cycle model pushes the expected
// output word at each posedge, and the DUT outputs are popped/compared at negedge.
module tb_clock_divider_ctrl;

    // MAX_DIV lowered to 200 so an over-range divisor (250) fits in the 8-bit port.
    localparam int unsigned MAXD = 200;
    localparam int unsigned DEFD = 9;
    localparam int unsigned W    = 8;

    logic         clk;
    logic         rst;
    logic         cfg_valid;
    logic         cfg_ready;
    logic [W-1:0] cfg_div;
    logic         cfg_en;
    logic         run_o, odd_o, half_o, wrap_o, busy_o, err_o;
    logic [W-1:0] div_o, cnt_o;

    int total = 0;
    int bad   = 0;
    int err_seen = 0;

    logic [31:0] sb_q[$];

    // Model state: 0 idle, 1 run, 2 pend
    int m_st, m_div, m_cnt, m_pd, m_pe, m_err;

    clock_divider_ctrl #(
        .MAX_DIV     (MAXD),
        .DEFAULT_DIV (DEFD)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cfg_valid_i (cfg_valid),
        .cfg_ready_o (cfg_ready),
        .cfg_div_i   (cfg_div),
        .cfg_en_i    (cfg_en),
        .run_o       (run_o),
        .div_o       (div_o),
        .odd_o       (odd_o),
        .cnt_o       (cnt_o),
        .half_o      (half_o),
        .wrap_o      (wrap_o),
        .busy_o      (busy_o),
        .err_o       (err_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack(input logic r, input logic [7:0] d, input logic o,
                                         input logic [7:0] c, input logic h, input logic w,
                                         input logic b, input logic rd, input logic e);
        return {9'b0, r, d, o, c, h, w, b, rd, e};
    endfunction

    // Reference model, evaluated on the inputs present at each rising edge.
    initial begin
        m_st = 0; m_div = DEFD; m_cnt = 0; m_pd = 0; m_pe = 0; m_err = 0;
        forever begin
            @(posedge clk);
            begin
                bit xfer, legal, wrapnow, r;
                int hp;
                if (rst) begin
                    m_st = 0; m_div = DEFD; m_cnt = 0; m_pd = 0; m_pe = 0; m_err = 0;
                end else begin
                    xfer    = cfg_valid && (m_st != 2);
                    legal   = !cfg_en || (int'(cfg_div) >= 2 && int'(cfg_div) <= MAXD);
                    wrapnow = (m_st != 0) && (m_cnt == m_div - 1);
                    m_err   = xfer && !legal;
                    if (m_st == 0)   m_cnt = 0;
                    else if (wrapnow) m_cnt = 0;
                    else             m_cnt = m_cnt + 1;
                    if (m_st == 0) begin
                        if (xfer && legal && cfg_en) begin
                            m_st = 1; m_div = int'(cfg_div); m_cnt = 0;
                        end
                    end else if (m_st == 1) begin
                        if (xfer && legal) begin
                            m_pd = int'(cfg_div); m_pe = cfg_en; m_st = 2;
                        end
                    end else if (wrapnow) begin
                        if (m_pe != 0) begin m_div = m_pd; m_st = 1; end
                        else m_st = 0;
                        m_cnt = 0;
                    end
                end
                r  = (m_st != 0);
                hp = m_div / 2 - 1;
                sb_q.push_back(pack(r, 8'(m_div), m_div[0], 8'(m_cnt),
                                    r && (m_cnt == hp), r && (m_cnt == m_div - 1),
                                    m_st == 2, m_st != 2, m_err != 0));
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (err_o === 1'b1) err_seen++;
            if (sb_q.size() > 0) begin
                logic [31:0] e;
                e = sb_q.pop_front();
                $display("cyc t=%0t run=%0b div=%0d cnt=%0d half=%0b wrap=%0b busy=%0b rdy=%0b err=%0b",
                         $time, run_o, div_o, cnt_o, half_o, wrap_o, busy_o, cfg_ready, err_o);
                check("cycle", pack(run_o, div_o, odd_o, cnt_o, half_o, wrap_o, busy_o, cfg_ready, err_o), e);
            end
        end
    end

    // Called at a negedge; holds valid until accepted, returns at the negedge after the transfer.
    task automatic send(input int d, input bit e);
        int n;
        cfg_valid = 1'b1;
        cfg_div   = 8'(d);
        cfg_en    = e;
        n = 0;
        while (cfg_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("send_rdy", 32'(cfg_ready), 32'd1);
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic wait_cnt(input int v);
        int n;
        n = 0;
        while (cnt_o !== 8'(v) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("wait_cnt", 32'(cnt_o), 32'(v));
    endtask

    task automatic wait_div(input int v);
        int n;
        n = 0;
        while (div_o !== 8'(v) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("wait_div", 32'(div_o), 32'(v));
    endtask

    initial begin
        rst = 1'b1; cfg_valid = 1'b0; cfg_div = '0; cfg_en = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_div", 32'(div_o), 32'(DEFD));
        check("rst_rdy", 32'(cfg_ready), 32'd1);
        repeat (2) @(negedge clk);

        // Start div=9 from IDLE
        send(9, 1'b1);
        repeat (25) @(negedge clk);
        check("run9", 32'(run_o), 32'd1);
        check("odd9", 32'(odd_o), 32'd1);

        // Change to 4 mid-period
        wait_cnt(2);
        send(4, 1'b1);
        wait_div(4);
        repeat (12) @(negedge clk);

        // Move to 6, then stop on a wrap cycle
        send(6, 1'b1);
        wait_div(6);
        wait_cnt(5);
        send(0, 1'b0);
        repeat (3) @(negedge clk);
        check("stop_pend", 32'(run_o), 32'd1);
        repeat (8) @(negedge clk);
        check("stop_run", 32'(run_o), 32'd0);
        check("stop_cnt", 32'(cnt_o), 32'd0);

        // Illegal requests from IDLE
        send(1, 1'b1);
        send(250, 1'b1);
        repeat (3) @(negedge clk);
        check("err_cnt2", 32'(err_seen), 32'd2);
        check("ill_div", 32'(div_o), 32'd6);
        check("ill_run", 32'(run_o), 32'd0);

        // div=2 from IDLE, plus an illegal request while running
        send(2, 1'b1);
        repeat (8) @(negedge clk);
        send(0, 1'b1);
        repeat (2) @(negedge clk);
        check("err_cnt3", 32'(err_seen), 32'd3);
        check("div2", 32'(div_o), 32'd2);

        // Reset while a change is pending
        send(8, 1'b1);
        check("pend_busy", 32'(busy_o), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("prst_div", 32'(div_o), 32'(DEFD));
        check("prst_busy", 32'(busy_o), 32'd0);
        check("prst_rdy", 32'(cfg_ready), 32'd1);
        check("prst_run", 32'(run_o), 32'd0);
        repeat (10) @(negedge clk);
        check("prst_keep", 32'(div_o), 32'(DEFD));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
